// File: rtl/cgra_pkg.sv
// Shared CGRA types and default widths for the PC path and the vector element sequencer.
package cgra_pkg;

  localparam int ADDR_W   = 12;
  localparam int LEN_W    = 12;
  localparam int STRIDE_W = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_INC  = 2'd2
  } step_op_t;

endpackage

// File: rtl/addr_stepper.sv
// One address stream: load a base, advance by the sign-extended stride, or hold.
// Registered output; the new address is visible the cycle after the op is applied.
module addr_stepper #(
  parameter int ADDR_W   = cgra_pkg::ADDR_W,
  parameter int STRIDE_W = cgra_pkg::STRIDE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  cgra_pkg::step_op_t   i_op,
  input  logic [ADDR_W-1:0]    i_base,
  input  logic [STRIDE_W-1:0]  i_stride,
  output logic [ADDR_W-1:0]    o_addr
);
  import cgra_pkg::*;

  localparam int EXT_W = ADDR_W - STRIDE_W;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_inc;

  // Negative strides become large unsigned increments, so the add wraps modulo 2^ADDR_W.
  assign w_inc = {{EXT_W{i_stride[STRIDE_W-1]}}, i_stride};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else begin
      case (i_op)
        STEP_LOAD: r_addr <= i_base;
        STEP_INC:  r_addr <= r_addr + w_inc;
        default:   r_addr <= r_addr;
      endcase
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/vect_auto_incr_seq.sv
// Vector element sequencer: steps element index and A/B/D addresses one element per cycle,
// N+2 cycles per vector launch; stall holds the current element, done pulses once at the end.
module vect_auto_incr_seq #(
  parameter int ADDR_W   = cgra_pkg::ADDR_W,
  parameter int LEN_W    = cgra_pkg::LEN_W,
  parameter int STRIDE_W = cgra_pkg::STRIDE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic                 is_not_vect,
  input  logic [LEN_W-1:0]     vec_len,
  input  logic [ADDR_W-1:0]    base_a,
  input  logic [ADDR_W-1:0]    base_b,
  input  logic [ADDR_W-1:0]    base_d,
  input  logic [STRIDE_W-1:0]  stride,
  input  logic                 stall,
  output logic                 elem_valid,
  output logic [LEN_W-1:0]     elem_idx,
  output logic [ADDR_W-1:0]    addr_a,
  output logic [ADDR_W-1:0]    addr_b,
  output logic [ADDR_W-1:0]    addr_d,
  output logic                 busy,
  output logic                 done_auto_incr
);
  import cgra_pkg::*;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  seq_state_t           r_state;
  seq_state_t           w_next;
  step_op_t             w_op;
  logic [LEN_W-1:0]     r_idx;
  logic [LEN_W-1:0]     r_last;
  logic [STRIDE_W-1:0]  r_stride;
  logic                 w_launch;
  logic                 w_last;

  assign w_launch = instr_valid & ~is_not_vect;
  assign w_last   = (r_idx == r_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs decode only the state register, so nothing combinational reaches them from inputs.
  always_comb begin
    w_next         = r_state;
    w_op           = STEP_HOLD;
    elem_valid     = 1'b0;
    busy           = 1'b0;
    done_auto_incr = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (w_launch) begin
          w_op   = STEP_LOAD;
          w_next = (vec_len != '0) ? SEQ_RUN : SEQ_DONE;
        end
      end
      SEQ_RUN: begin
        elem_valid = 1'b1;
        busy       = 1'b1;
        if (!stall) begin
          if (w_last) w_next = SEQ_DONE;
          else        w_op   = STEP_INC;
        end
      end
      SEQ_DONE: begin
        busy           = 1'b1;
        done_auto_incr = 1'b1;
        w_next         = SEQ_IDLE;
      end
      default: w_next = SEQ_IDLE;
    endcase
  end

  // N-1 is latched at launch so the end-of-vector compare never depends on live inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_last   <= '0;
      r_stride <= '0;
    end else if (w_op == STEP_LOAD) begin
      r_idx    <= '0;
      r_last   <= vec_len - LEN_ONE;
      r_stride <= stride;
    end else if (w_op == STEP_INC) begin
      r_idx    <= r_idx + LEN_ONE;
    end
  end

  assign elem_idx = r_idx;

  addr_stepper #(.ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)) u_step_a (
    .clk(clk), .rst(rst), .i_op(w_op), .i_base(base_a), .i_stride(r_stride), .o_addr(addr_a)
  );

  addr_stepper #(.ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)) u_step_b (
    .clk(clk), .rst(rst), .i_op(w_op), .i_base(base_b), .i_stride(r_stride), .o_addr(addr_b)
  );

  addr_stepper #(.ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)) u_step_d (
    .clk(clk), .rst(rst), .i_op(w_op), .i_base(base_d), .i_stride(r_stride), .o_addr(addr_d)
  );

endmodule

// File: tb/tb_vect_auto_incr_seq.sv
// Directed bench for vect_auto_incr_seq; expected values are hand-computed constants.
module tb_vect_auto_incr_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        is_not_vect;
  logic [11:0] vec_len;
  logic [11:0] base_a;
  logic [11:0] base_b;
  logic [11:0] base_d;
  logic [7:0]  stride;
  logic        stall;
  logic        elem_valid;
  logic [11:0] elem_idx;
  logic [11:0] addr_a;
  logic [11:0] addr_b;
  logic [11:0] addr_d;
  logic        busy;
  logic        done_auto_incr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vect_auto_incr_seq dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .is_not_vect(is_not_vect),
    .vec_len(vec_len), .base_a(base_a), .base_b(base_b), .base_d(base_d),
    .stride(stride), .stall(stall), .elem_valid(elem_valid), .elem_idx(elem_idx),
    .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d), .busy(busy),
    .done_auto_incr(done_auto_incr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_elem(input string tag, input int idx,
                          input logic [11:0] a, input logic [11:0] b, input logic [11:0] d);
    chk({tag, "_ev"},   32'(elem_valid), 32'd1);
    chk({tag, "_done"}, 32'(done_auto_incr), 32'd0);
    chk({tag, "_idx"},  32'(elem_idx), 32'(idx));
    chk({tag, "_a"},    32'(addr_a), 32'(a));
    chk({tag, "_b"},    32'(addr_b), 32'(b));
    chk({tag, "_d"},    32'(addr_d), 32'(d));
  endtask

  task automatic exp_done(input string tag);
    chk({tag, "_done"}, 32'(done_auto_incr), 32'd1);
    chk({tag, "_ev"},   32'(elem_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, "_done"}, 32'(done_auto_incr), 32'd0);
    chk({tag, "_ev"},   32'(elem_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic present(input logic [11:0] n, input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] d, input logic [7:0] s);
    instr_valid = 1'b1;
    is_not_vect = 1'b0;
    vec_len     = n;
    base_a      = a;
    base_b      = b;
    base_d      = d;
    stride      = s;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; is_not_vect = 1'b0; vec_len = '0;
    base_a = '0; base_b = '0; base_d = '0; stride = '0; stall = 1'b0;
    tick; tick;
    exp_idle("rst");
    chk("rst_idx", 32'(elem_idx), 32'd0);
    chk("rst_a",   32'(addr_a), 32'd0);
    chk("rst_d",   32'(addr_d), 32'd0);

    // 1: reset held three cycles while at element 3 of an 8-element run
    rst = 1'b0;
    present(12'd8, 12'h100, 12'h200, 12'h300, 8'h01);
    tick;
    instr_valid = 1'b0;
    tick; tick; tick;
    exp_elem("t1_pre", 3, 12'h103, 12'h203, 12'h303);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t1_nodone", 32'(done_auto_incr), 32'd0);
    end
    exp_idle("t1_rst");
    chk("t1_idx", 32'(elem_idx), 32'd0);
    chk("t1_a",   32'(addr_a), 32'd0);
    chk("t1_b",   32'(addr_b), 32'd0);
    chk("t1_d",   32'(addr_d), 32'd0);
    rst = 1'b0;
    tick;
    exp_idle("t1_after");

    // 2: N=4, stride +1, no stall; done in cycle 6 counting the launch cycle as 1
    present(12'd4, 12'h010, 12'h020, 12'h030, 8'h01);
    tick;
    instr_valid = 1'b0;
    exp_elem("t2_e0", 0, 12'h010, 12'h020, 12'h030);
    tick; exp_elem("t2_e1", 1, 12'h011, 12'h021, 12'h031);
    tick; exp_elem("t2_e2", 2, 12'h012, 12'h022, 12'h032);
    tick; exp_elem("t2_e3", 3, 12'h013, 12'h023, 12'h033);
    tick; exp_done("t2_done");
    tick; exp_idle("t2_idle");

    // 3: same vector, stall held two cycles on elements 1 and 2
    present(12'd4, 12'h010, 12'h020, 12'h030, 8'h01);
    tick;
    instr_valid = 1'b0;
    exp_elem("t3_e0", 0, 12'h010, 12'h020, 12'h030);
    tick; exp_elem("t3_e1a", 1, 12'h011, 12'h021, 12'h031);
    stall = 1'b1;
    tick; exp_elem("t3_e1b", 1, 12'h011, 12'h021, 12'h031);
    tick; exp_elem("t3_e1c", 1, 12'h011, 12'h021, 12'h031);
    stall = 1'b0;
    tick; exp_elem("t3_e2a", 2, 12'h012, 12'h022, 12'h032);
    stall = 1'b1;
    tick; exp_elem("t3_e2b", 2, 12'h012, 12'h022, 12'h032);
    tick; exp_elem("t3_e2c", 2, 12'h012, 12'h022, 12'h032);
    stall = 1'b0;
    tick; exp_elem("t3_e3", 3, 12'h013, 12'h023, 12'h033);
    tick; exp_done("t3_done");
    stall = 1'b1;
    tick; exp_idle("t3_idle");
    stall = 1'b0;

    // 4: negative stride wraps through zero
    present(12'd3, 12'h001, 12'h800, 12'h000, 8'hFE);
    tick;
    instr_valid = 1'b0;
    exp_elem("t4_e0", 0, 12'h001, 12'h800, 12'h000);
    tick; exp_elem("t4_e1", 1, 12'hFFF, 12'h7FE, 12'hFFE);
    tick; exp_elem("t4_e2", 2, 12'hFFD, 12'h7FC, 12'hFFC);
    tick; exp_done("t4_done");
    tick; exp_idle("t4_idle");

    // 5: zero-length vector, then a scalar instruction
    present(12'd0, 12'h055, 12'h066, 12'h077, 8'h01);
    tick;
    instr_valid = 1'b0;
    exp_done("t5_zero");
    tick; exp_idle("t5_zero_idle");
    present(12'd5, 12'h010, 12'h020, 12'h030, 8'h01);
    is_not_vect = 1'b1;
    tick; exp_idle("t5_scalar1");
    tick; exp_idle("t5_scalar2");
    instr_valid = 1'b0;
    is_not_vect = 1'b0;
    tick; exp_idle("t5_scalar3");

    // 6: N=2 then N=1 back to back; inputs swapped to the second instruction mid-run
    present(12'd2, 12'h040, 12'h050, 12'h060, 8'h04);
    tick;
    present(12'd1, 12'h0A0, 12'h0B0, 12'h0C0, 8'hFF);
    exp_elem("t6_a0", 0, 12'h040, 12'h050, 12'h060);
    tick; exp_elem("t6_a1", 1, 12'h044, 12'h054, 12'h064);
    tick; exp_done("t6_done1");
    tick; exp_idle("t6_gap");
    tick; exp_elem("t6_b0", 0, 12'h0A0, 12'h0B0, 12'h0C0);
    instr_valid = 1'b0;
    tick; exp_done("t6_done2");
    tick; exp_idle("t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
